// File: rtl/apb_xfer_arbiter.sv
// apb_xfer_arbiter: round-robin arbiter sharing one APB master's transfer-request interface
// between NREQ local requesters. The winning command is latched and held on the m_* outputs
// until the master reports completion or the watchdog expires. The owner then gets a one-cycle
// done pulse with err and rdata.
//
// Ports:
//   PCLK, PRESET           clock, asynchronous active-high reset
//   req, req_write         per-requester request (level) and direction (1=write)
//   req_addr, req_wdata    flattened per-requester address / write data ([i*W +: W])
//   gnt                    one-hot owner of the current transfer
//   done, err, rdata       completion pulse to owner, abort flag, read data (held until next done)
//   m_transfer, m_write    master transfer request and READ_WRITE
//   m_addr, m_wdata        master address and write data
//   m_rdata, m_done        master read data and completion pulse
module apb_xfer_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned AW      = 8,
  parameter int unsigned DW      = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic               PCLK,
  input  logic               PRESET,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    req_write,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    done,
  output logic               err,
  output logic [DW-1:0]      rdata,
  output logic               m_transfer,
  output logic               m_write,
  output logic [AW-1:0]      m_addr,
  output logic [DW-1:0]      m_wdata,
  input  logic [DW-1:0]      m_rdata,
  input  logic               m_done
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CntLast = CW'(TIMEOUT - 1);
  localparam logic [IW-1:0] IdxLast = IW'(NREQ - 1);
  localparam logic [IW:0]   NreqW   = (IW + 1)'(NREQ);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e        state_q;
  logic [IW-1:0] ptr_q;
  logic [IW-1:0] idx_q;
  logic [CW-1:0] cnt_q;

  logic [IW-1:0] sel;
  logic          sel_vld;
  logic [IW:0]   sum;
  logic [IW-1:0] cand;

  // Rotating priority search: walk offsets from high to low so the smallest offset from ptr_q
  // that has a request is the last (winning) assignment.
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    sum     = '0;
    cand    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr_q} + (IW + 1)'(k);
      if (sum >= NreqW) sum = sum - NreqW;
      cand = sum[IW-1:0];
      if (req[cand]) begin
        sel     = cand;
        sel_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      gnt        <= '0;
      done       <= '0;
      err        <= 1'b0;
      rdata      <= '0;
      m_transfer <= 1'b0;
      m_write    <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
    end else begin
      // done/err are single-cycle pulses; rdata is only touched on completion.
      done <= '0;
      err  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (sel_vld) begin
            idx_q      <= sel;
            gnt        <= '0;
            gnt[sel]   <= 1'b1;
            m_transfer <= 1'b1;
            m_write    <= req_write[sel];
            m_addr     <= req_addr[int'(sel) * AW +: AW];
            m_wdata    <= req_wdata[int'(sel) * DW +: DW];
            cnt_q      <= '0;
            state_q    <= StBusy;
          end
        end
        StBusy: begin
          // m_done takes precedence over a watchdog expiry in the same cycle.
          if (m_done || (cnt_q == CntLast)) begin
            done[idx_q] <= 1'b1;
            err         <= ~m_done;
            rdata       <= (m_done && !m_write) ? m_rdata : '0;
            m_transfer  <= 1'b0;
            m_write     <= 1'b0;
            gnt         <= '0;
            ptr_q       <= (idx_q == IdxLast) ? '0 : idx_q + IW'(1);
            state_q     <= StIdle;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_xfer_arbiter.sv
module tb_apb_xfer_arbiter;

  localparam int NREQ    = 4;
  localparam int AW      = 8;
  localparam int DW      = 8;
  localparam int TIMEOUT = 16;

  logic               PCLK;
  logic               PRESET;
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    req_write;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic               err;
  logic [DW-1:0]      rdata;
  logic               m_transfer;
  logic               m_write;
  logic [AW-1:0]      m_addr;
  logic [DW-1:0]      m_wdata;
  logic [DW-1:0]      m_rdata;
  logic               m_done;

  int total = 0;
  int bad   = 0;
  int ptr_m = 0;

  apb_xfer_arbiter #(
    .NREQ   (NREQ),
    .AW     (AW),
    .DW     (DW),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .req       (req),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .m_transfer(m_transfer),
    .m_write   (m_write),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_rdata   (m_rdata),
    .m_done    (m_done)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Reference arbitration: first requester at or after ptr, wrapping.
  function automatic int pick(input int ptr, input logic [NREQ-1:0] r);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic apply_reset();
    @(negedge PCLK);
    PRESET = 1'b1;
    req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    m_done = 1'b0; m_rdata = '0;
    @(negedge PCLK);
    PRESET = 1'b0;
    ptr_m = 0;
  endtask

  // Waits (bounded) for m_transfer; g = negedges waited, >20 means it never came.
  task automatic wait_grant(output int g);
    g = 0;
    do begin
      @(negedge PCLK);
      g++;
    end while (m_transfer !== 1'b1 && g <= 20);
  endtask

  // Acts as the master: pulses m_done in BUSY cycle d, returns how many cycles m_transfer was
  // high. Ends on the first negedge with m_transfer low (the done cycle).
  task automatic run_busy(input int d, input logic [DW-1:0] rd, output int hi);
    hi = 0;
    while (m_transfer === 1'b1 && hi < 64) begin
      m_done  = (hi == d);
      m_rdata = rd;
      hi++;
      @(negedge PCLK);
    end
    m_done = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if ({gnt, done, err, rdata, m_transfer, m_write, m_addr, m_wdata} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: gnt=%b done=%b err=%b rdata=%h xfer=%b wr=%b addr=%h wd=%h want all 0",
               gnt, done, err, rdata, m_transfer, m_write, m_addr, m_wdata);
    end
  endtask

  task automatic test_single_read();
    int g, hi;
    req_write = '0;
    req_addr  = (NREQ*AW)'(32'h0045_0000);
    req       = 4'b0100;
    wait_grant(g);
    total++;
    if (g !== 1 || gnt !== 4'b0100 || m_addr !== 8'h45 || m_write !== 1'b0) begin
      bad++;
      $display("FAIL single_cmd: wait=%0d gnt=%b addr=%h wr=%b want 1 0100 45 0", g, gnt, m_addr, m_write);
    end
    run_busy(3, 8'hA5, hi);
    total++;
    if (hi !== 4) begin
      bad++;
      $display("FAIL single_len: got %0d cycles want 4", hi);
    end
    total++;
    if (done !== 4'b0100 || rdata !== 8'hA5 || err !== 1'b0) begin
      bad++;
      $display("FAIL single_done: done=%b rdata=%h err=%b want 0100 a5 0", done, rdata, err);
    end
    req = '0;
    @(negedge PCLK);
    total++;
    if (done !== '0 || rdata !== 8'hA5) begin
      bad++;
      $display("FAIL single_pulse: done=%b rdata=%h want 0000 a5", done, rdata);
    end
  endtask

  task automatic test_round_robin();
    int g, hi;
    apply_reset();
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_grant(g);
      total++;
      if (g !== 1 || gnt !== 4'(1 << (n % NREQ))) begin
        bad++;
        $display("FAIL rr_grant%0d: wait=%0d gnt=%b want 1 %b", n, g, gnt, 4'(1 << (n % NREQ)));
      end
      run_busy(1, 8'(n), hi);
      total++;
      if (hi !== 2 || done !== 4'(1 << (n % NREQ))) begin
        bad++;
        $display("FAIL rr_done%0d: len=%0d done=%b want 2 %b", n, hi, done, 4'(1 << (n % NREQ)));
      end
    end
    req = '0;
  endtask

  task automatic test_ptr_wrap();
    int g, hi;
    apply_reset();
    req = 4'b1000;
    wait_grant(g);
    run_busy(0, 8'h00, hi);
    req = 4'b1001;
    wait_grant(g);
    total++;
    if (g !== 1 || gnt !== 4'b0001) begin
      bad++;
      $display("FAIL wrap_first: wait=%0d gnt=%b want 1 0001", g, gnt);
    end
    run_busy(0, 8'h00, hi);
    wait_grant(g);
    total++;
    if (g !== 1 || gnt !== 4'b1000) begin
      bad++;
      $display("FAIL wrap_second: wait=%0d gnt=%b want 1 1000", g, gnt);
    end
    run_busy(0, 8'h00, hi);
    req = '0;
  endtask

  task automatic test_watchdog();
    int g, hi;
    apply_reset();
    req_write = 4'b0010;
    req       = 4'b0110;
    wait_grant(g);
    total++;
    if (gnt !== 4'b0010 || m_write !== 1'b1) begin
      bad++;
      $display("FAIL wd_grant: gnt=%b wr=%b want 0010 1", gnt, m_write);
    end
    run_busy(1000, 8'hFF, hi);
    total++;
    if (hi !== TIMEOUT || done !== 4'b0010 || err !== 1'b1 || rdata !== 8'h00) begin
      bad++;
      $display("FAIL wd_abort: len=%0d done=%b err=%b rdata=%h want %0d 0010 1 00",
               hi, done, err, rdata, TIMEOUT);
    end
    req = 4'b0100;
    wait_grant(g);
    total++;
    if (g !== 1 || gnt !== 4'b0100) begin
      bad++;
      $display("FAIL wd_next: wait=%0d gnt=%b want 1 0100", g, gnt);
    end
    run_busy(2, 8'h3C, hi);
    total++;
    if (done !== 4'b0100 || err !== 1'b0 || rdata !== 8'h3C) begin
      bad++;
      $display("FAIL wd_next_done: done=%b err=%b rdata=%h want 0100 0 3c", done, err, rdata);
    end
    req = '0; req_write = '0;
  endtask

  task automatic test_collision_cancel();
    int g, hi;
    req_write = '0;
    req = 4'b0001;
    wait_grant(g);
    run_busy(TIMEOUT - 1, 8'h5A, hi);
    total++;
    if (hi !== TIMEOUT || done !== 4'b0001 || err !== 1'b0 || rdata !== 8'h5A) begin
      bad++;
      $display("FAIL collision: len=%0d done=%b err=%b rdata=%h want %0d 0001 0 5a",
               hi, done, err, rdata, TIMEOUT);
    end
    req_addr = (NREQ*AW)'(32'h0033_0000);
    req = 4'b0100;
    wait_grant(g);
    req = '0;
    req_addr = '1;
    run_busy(4, 8'h77, hi);
    total++;
    if (hi !== 5 || done !== 4'b0100 || rdata !== 8'h77 || m_addr !== 8'h33) begin
      bad++;
      $display("FAIL cancel: len=%0d done=%b rdata=%h addr=%h want 5 0100 77 33", hi, done, rdata, m_addr);
    end
    req_addr = '0;
  endtask

  task automatic test_async_reset();
    int g, hi;
    req = 4'b0001;
    wait_grant(g);
    @(negedge PCLK);
    #2 PRESET = 1'b1;
    #1;
    total++;
    if (m_transfer !== 1'b0 || gnt !== '0 || done !== '0 || m_addr !== '0) begin
      bad++;
      $display("FAIL areset_busy: xfer=%b gnt=%b done=%b addr=%h want 0", m_transfer, gnt, done, m_addr);
    end
    req = '0;
    @(negedge PCLK);
    PRESET = 1'b0;
    ptr_m = 0;
    req = 4'b1000;
    wait_grant(g);
    total++;
    if (g !== 1 || gnt !== 4'b1000) begin
      bad++;
      $display("FAIL areset_regrant: wait=%0d gnt=%b want 1 1000", g, gnt);
    end
    run_busy(0, 8'h99, hi);
    req = '0;
    #2 PRESET = 1'b1;
    #1;
    total++;
    if (done !== '0 || rdata !== '0) begin
      bad++;
      $display("FAIL areset_done: done=%b rdata=%h want 0000 00", done, rdata);
    end
    @(negedge PCLK);
    PRESET = 1'b0;
  endtask

  task automatic test_random();
    int e, d, hi, exp_hi;
    logic [NREQ-1:0] r;
    logic [DW-1:0]   rd, exp_rd, rd_m;
    logic            ew, exp_err;
    logic [AW-1:0]   ea;
    logic [DW-1:0]   ewd;
    apply_reset();
    rd_m = '0;
    for (int it = 0; it < 60; it++) begin
      if (it % 8 == 7) begin
        req = '0; m_done = 1'b1; m_rdata = DW'($urandom);
        @(negedge PCLK);
        m_done = 1'b0;
        total++;
        if (m_transfer !== 1'b0 || done !== '0 || rdata !== rd_m) begin
          bad++;
          $display("FAIL rnd_idle_mdone%0d: xfer=%b done=%b rdata=%h want 0 0000 %h",
                   it, m_transfer, done, rdata, rd_m);
        end
      end
      r = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      req_write = NREQ'($urandom);
      req_addr  = (NREQ*AW)'($urandom);
      req_wdata = (NREQ*DW)'($urandom);
      req = r;
      e   = pick(ptr_m, r);
      ew  = req_write[e];
      ea  = req_addr[e*AW +: AW];
      ewd = req_wdata[e*DW +: DW];
      @(negedge PCLK);
      total++;
      if (gnt !== NREQ'(1 << e) || m_transfer !== 1'b1 || done !== '0 || rdata !== rd_m) begin
        bad++;
        $display("FAIL rnd_grant%0d: gnt=%b xfer=%b done=%b rdata=%h want %b 1 0000 %h",
                 it, gnt, m_transfer, done, rdata, NREQ'(1 << e), rd_m);
      end
      total++;
      if (m_write !== ew || m_addr !== ea || m_wdata !== ewd) begin
        bad++;
        $display("FAIL rnd_cmd%0d: wr=%b addr=%h wd=%h want %b %h %h", it, m_write, m_addr, m_wdata,
                 ew, ea, ewd);
      end
      // Requester inputs change freely while the transfer is in flight.
      req       = NREQ'($urandom);
      req_write = NREQ'($urandom);
      req_addr  = (NREQ*AW)'($urandom);
      req_wdata = (NREQ*DW)'($urandom);
      d  = $urandom_range(0, TIMEOUT + 3);
      rd = DW'($urandom);
      run_busy(d, rd, hi);
      exp_err = (d > TIMEOUT - 1);
      exp_hi  = exp_err ? TIMEOUT : d + 1;
      exp_rd  = (exp_err || ew) ? '0 : rd;
      total++;
      if (hi !== exp_hi) begin
        bad++;
        $display("FAIL rnd_len%0d: got %0d cycles want %0d", it, hi, exp_hi);
      end
      total++;
      if (done !== NREQ'(1 << e) || err !== exp_err || rdata !== exp_rd) begin
        bad++;
        $display("FAIL rnd_done%0d: done=%b err=%b rdata=%h want %b %b %h", it, done, err, rdata,
                 NREQ'(1 << e), exp_err, exp_rd);
      end
      total++;
      if (gnt !== '0 || m_addr !== ea || m_wdata !== ewd) begin
        bad++;
        $display("FAIL rnd_hold%0d: gnt=%b addr=%h wd=%h want 0000 %h %h", it, gnt, m_addr, m_wdata,
                 ea, ewd);
      end
      rd_m  = exp_rd;
      ptr_m = (e + 1) % NREQ;
    end
    req = '0;
  endtask

  initial begin
    PRESET = 1'b1;
    req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    m_done = 1'b0; m_rdata = '0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_ptr_wrap();
    test_watchdog();
    test_collision_cancel();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
